// File: rtl/ecc_enc_pkg.sv
// ecc_enc_pkg
// Shared definitions for the streaming SECDED encoder:
//   mode_e       codeword-width selector (8/16/32 bit, plus illegal code)
//   K_*/P_*      data and parity bit counts per mode
//   data_pos     data index -> Hamming position (3,5,6,7,9,...)
//   cover_mask   data bits covered by parity bit j
//   data_mask    K-bit mask of the payload for a mode
package ecc_enc_pkg;

    typedef enum logic [1:0] {
        MODE_S   = 2'b00,
        MODE_M   = 2'b01,
        MODE_L   = 2'b10,
        MODE_ILL = 2'b11
    } mode_e;

    localparam int K_S = 4;
    localparam int P_S = 4;
    localparam int K_M = 11;
    localparam int P_M = 5;
    localparam int K_L = 26;
    localparam int P_L = 6;

    localparam int DATA_MAX = K_L;
    localparam int CW_MAX   = K_L + P_L;
    localparam int PJ_MAX   = P_L - 1;

    // Position of data bit idx: the idx-th non-power-of-two position >= 3.
    function automatic int data_pos(input int idx);
        int n;
        int pos;
        n   = 0;
        pos = 0;
        for (int p = 3; p < CW_MAX; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == idx) pos = p;
                n = n + 1;
            end
        end
        return pos;
    endfunction

    function automatic logic [DATA_MAX-1:0] cover_mask(input int bit_idx);
        logic [DATA_MAX-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_MAX; i++) begin
            if (((data_pos(i) >> bit_idx) & 1) != 0) m[i] = 1'b1;
        end
        return m;
    endfunction

    function automatic logic [DATA_MAX-1:0] data_mask(input mode_e mode);
        logic [DATA_MAX-1:0] m;
        case (mode)
            MODE_S:  m = 26'h000000F;
            MODE_M:  m = 26'h00007FF;
            MODE_L:  m = 26'h3FFFFFF;
            default: m = '0;
        endcase
        return m;
    endfunction

endpackage

// File: rtl/ecc_parity_gen.sv
// ecc_parity_gen
// Combinational SECDED codeword builder.
//   data      masked payload (bits above K must already be zero)
//   mode      codeword width selector
//   codeword  {data, p_ov, p_{P-2..0}}, right-justified, zero above K+P
//   err       illegal width requested; codeword forced to zero
module ecc_parity_gen
    import ecc_enc_pkg::*;
(
    input  logic [DATA_MAX-1:0] data,
    input  mode_e               mode,
    output logic [CW_MAX-1:0]   codeword,
    output logic                err
);

    logic [PJ_MAX-1:0] p;
    logic              p_ov;

    // Because the payload is pre-masked, parity bits beyond the active mode's
    // P-1 evaluate to zero, so one set of masks serves every width and the
    // overall parity can fold in all of p.
    for (genvar j = 0; j < PJ_MAX; j++) begin : g_par
        localparam logic [DATA_MAX-1:0] COVER = cover_mask(j);
        assign p[j] = ^(data & COVER);
    end

    assign p_ov = (^data) ^ (^p);

    always_comb begin
        codeword = '0;
        err      = 1'b0;
        case (mode)
            MODE_S:  codeword = {24'b0, data[K_S-1:0], p_ov, p[P_S-2:0]};
            MODE_M:  codeword = {16'b0, data[K_M-1:0], p_ov, p[P_M-2:0]};
            MODE_L:  codeword = {data[K_L-1:0], p_ov, p[P_L-2:0]};
            default: err      = 1'b1;
        endcase
    end

endmodule

// File: rtl/ecc_stream_encoder.sv
// ecc_stream_encoder
// Streaming SECDED encoder, 2-stage elastic pipeline, 1 word/cycle.
//   clk, rst              clock; asynchronous active-low reset
//   in_valid/in_ready     input handshake (DATA_IN, CODEWORD_WIDTH)
//   out_valid/out_ready   output handshake (Enc_Out, out_err)
//   enc_count             completed output handshakes, wrapping
module ecc_stream_encoder
    import ecc_enc_pkg::*;
#(
    parameter int AMBA_WORD = 32,
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [AMBA_WORD-1:0] DATA_IN,
    input  logic [1:0]           CODEWORD_WIDTH,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [AMBA_WORD-1:0] Enc_Out,
    output logic                 out_err,
    output logic [CNT_WIDTH-1:0] enc_count
);

    logic                s1_valid;
    logic [DATA_MAX-1:0] s1_data;
    mode_e               s1_mode;

    logic                s2_valid;
    logic [CW_MAX-1:0]   s2_cw;
    logic                s2_err;

    logic [CW_MAX-1:0]   cw;
    logic                cw_err;
    logic                s2_load;
    logic                s1_advance;
    logic                s1_load;
    mode_e               in_mode;
    logic                data_unused;

    // Payload bits above the widest K are never encoded.
    assign data_unused = ^DATA_IN[AMBA_WORD-1:DATA_MAX];

    assign in_mode    = mode_e'(CODEWORD_WIDTH);
    assign s2_load    = !s2_valid || out_ready;
    assign s1_advance = s1_valid && s2_load;
    assign s1_load    = !s1_valid || s1_advance;
    assign in_ready   = s1_load;

    ecc_parity_gen u_parity (
        .data     (s1_data),
        .mode     (s1_mode),
        .codeword (cw),
        .err      (cw_err)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_data  <= '0;
            s1_mode  <= MODE_S;
        end else if (s1_load) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_data <= DATA_IN[DATA_MAX-1:0] & data_mask(in_mode);
                s1_mode <= in_mode;
            end
        end
    end

    // out_err is cleared whenever stage 2 drains so it is only seen with out_valid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_cw    <= '0;
            s2_err   <= 1'b0;
        end else if (s2_load) begin
            s2_valid <= s1_valid;
            s2_err   <= s1_valid && cw_err;
            if (s1_valid) s2_cw <= cw;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            enc_count <= '0;
        end else if (s2_valid && out_ready) begin
            enc_count <= enc_count + CNT_WIDTH'(1);
        end
    end

    assign out_valid = s2_valid;
    assign out_err   = s2_err;
    assign Enc_Out   = AMBA_WORD'(s2_cw);

endmodule

// File: tb/tb_ecc_stream_encoder.sv
module tb_ecc_stream_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] DATA_IN;
    logic [1:0]  CODEWORD_WIDTH;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] Enc_Out;
    logic        out_err;
    logic [15:0] enc_count;

    int checks   = 0;
    int failures = 0;

    ecc_stream_encoder #(.AMBA_WORD(32), .CNT_WIDTH(16)) dut (
        .clk            (clk),
        .rst            (rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .DATA_IN        (DATA_IN),
        .CODEWORD_WIDTH (CODEWORD_WIDTH),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .Enc_Out        (Enc_Out),
        .out_err        (out_err),
        .enc_count      (enc_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] w, input logic [31:0] d);
        in_valid       = 1'b1;
        CODEWORD_WIDTH = w;
        DATA_IN        = d;
    endtask

    // Single word with out_ready=1: accept, wait (bounded), check, complete.
    task automatic send_and_expect(input string tag, input logic [1:0] w,
                                   input logic [31:0] d, input logic [31:0] exp_cw,
                                   input logic exp_err);
        int n;
        out_ready = 1'b1;
        drive(w, d);
        check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        n = 0;
        while (!out_valid && n < 8) begin
            step();
            n++;
        end
        check({tag, "_out_valid"}, {31'b0, out_valid}, 32'd1);
        check({tag, "_cw"}, Enc_Out, exp_cw);
        check({tag, "_err"}, {31'b0, out_err}, {31'b0, exp_err});
        step();
    endtask

    initial begin
        rst            = 1'b0;
        in_valid       = 1'b0;
        out_ready      = 1'b0;
        DATA_IN        = '0;
        CODEWORD_WIDTH = 2'b00;
        #1;
        check("rst_out_valid", {31'b0, out_valid}, 32'd0);
        check("rst_enc_out", Enc_Out, 32'd0);
        check("rst_out_err", {31'b0, out_err}, 32'd0);
        check("rst_enc_count", {16'b0, enc_count}, 32'd0);
        step();
        step();
        rst = 1'b1;

        // First word: exact 2-cycle latency
        step();
        out_ready = 1'b1;
        drive(2'b00, 32'h0000000B);
        check("t1_in_ready", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("t1_not_yet", {31'b0, out_valid}, 32'd0);
        step();
        check("t1_out_valid", {31'b0, out_valid}, 32'd1);
        check("t1_cw", Enc_Out, 32'h000000B1);
        check("t1_err", {31'b0, out_err}, 32'd0);
        step();
        check("t1_count", {16'b0, enc_count}, 32'd1);
        check("t1_drained", {31'b0, out_valid}, 32'd0);

        // Back-to-back stream of three widths
        begin
            logic [1:0]  sw [3];
            logic [31:0] sd [3];
            logic [31:0] se [3];
            sw[0] = 2'b00; sd[0] = 32'h0000000F; se[0] = 32'h000000FF;
            sw[1] = 2'b01; sd[1] = 32'h000007FF; se[1] = 32'h0000FFFF;
            sw[2] = 2'b10; sd[2] = 32'h03FFFFFF; se[2] = 32'hFFFFFFFF;
            for (int c = 0; c < 5; c++) begin
                if (c < 3) drive(sw[c], sd[c]);
                else in_valid = 1'b0;
                check($sformatf("s_in_ready%0d", c), {31'b0, in_ready}, 32'd1);
                if (c >= 2) begin
                    check($sformatf("s_valid%0d", c - 2), {31'b0, out_valid}, 32'd1);
                    check($sformatf("s_cw%0d", c - 2), Enc_Out, se[c - 2]);
                end
                step();
            end
            check("s_count", {16'b0, enc_count}, 32'd4);
            check("s_drained", {31'b0, out_valid}, 32'd0);
        end

        // Upper-bit masking and illegal width
        send_and_expect("mask", 2'b00, 32'hFFFFFFF0, 32'h00000000, 1'b0);
        check("mask_count", {16'b0, enc_count}, 32'd5);
        send_and_expect("ill", 2'b11, 32'h12345678, 32'h00000000, 1'b1);
        check("ill_count", {16'b0, enc_count}, 32'd6);
        check("ill_err_clear", {31'b0, out_err}, 32'd0);

        // Backpressure: two held, third stalls, then everything shifts
        out_ready = 1'b0;
        drive(2'b00, 32'h0000000B);
        check("bp_rdy0", {31'b0, in_ready}, 32'd1);
        step();
        drive(2'b01, 32'h000007FF);
        check("bp_rdy1", {31'b0, in_ready}, 32'd1);
        step();
        drive(2'b10, 32'h03FFFFFF);
        for (int c = 0; c < 3; c++) begin
            check($sformatf("bp_stall_rdy%0d", c), {31'b0, in_ready}, 32'd0);
            check($sformatf("bp_hold_valid%0d", c), {31'b0, out_valid}, 32'd1);
            check($sformatf("bp_hold_cw%0d", c), Enc_Out, 32'h000000B1);
            step();
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_rdy", {31'b0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        check("bp_w1_valid", {31'b0, out_valid}, 32'd1);
        check("bp_w1_cw", Enc_Out, 32'h0000FFFF);
        step();
        check("bp_w2_valid", {31'b0, out_valid}, 32'd1);
        check("bp_w2_cw", Enc_Out, 32'hFFFFFFFF);
        step();
        check("bp_drained", {31'b0, out_valid}, 32'd0);
        check("bp_count", {16'b0, enc_count}, 32'd9);

        // Reset while two words are held
        out_ready = 1'b0;
        drive(2'b00, 32'h0000000F);
        step();
        drive(2'b01, 32'h000007FF);
        step();
        in_valid = 1'b0;
        check("mr_held", {31'b0, out_valid}, 32'd1);
        #2;
        rst = 1'b0;
        #1;
        check("mr_valid", {31'b0, out_valid}, 32'd0);
        check("mr_count", {16'b0, enc_count}, 32'd0);
        check("mr_cw", Enc_Out, 32'd0);
        step();
        rst = 1'b1;
        step();
        send_and_expect("mr_new", 2'b00, 32'h0000000B, 32'h000000B1, 1'b0);
        check("mr_new_count", {16'b0, enc_count}, 32'd1);
        check("mr_new_drained", {31'b0, out_valid}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/ecc_stream_encoder.md
Name: ecc_stream_encoder

Overview:
- Streaming SECDED (extended Hamming) encoder supporting three codeword widths: 8, 16 and 32 bits.
- The width is selected per word, so consecutive words may use different widths.
- Valid/ready handshakes on both input and output; 2-stage elastic pipeline; full throughput of 1 word/cycle.
- Sits between the APB register file (data/width source) and the channel/noise stage; feeds the decoder path.

Parameters:
- AMBA_WORD, 32, data-in and codeword-out bus width; must be ≥32.
- CNT_WIDTH, 16, width of the encoded-word counter.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  asynchronous, active-low reset.
- in_valid  input  1  DATA_IN/CODEWORD_WIDTH are valid.
- in_ready  output  1  encoder accepts the word this cycle.
- DATA_IN  input  AMBA_WORD  payload, right-justified; bits above K ignored.
- CODEWORD_WIDTH  input  2  00=8b (K=4,P=4), 01=16b (K=11,P=5), 10=32b (K=26,P=6), 11=illegal.
- out_valid  output  1  Enc_Out is valid.
- out_ready  input  1  downstream accepts.
- Enc_Out  output  AMBA_WORD  codeword, right-justified, zero-extended.
- out_err  output  1  the word was submitted with illegal width 11.
- enc_count  output  CNT_WIDTH  number of completed output handshakes.

Behaviour:
- Reset (rst=0, async): out_valid=0, Enc_Out=0, out_err=0, enc_count=0, both pipeline stages empty; in_ready=1 once rst=1. A word in flight is discarded.
- Input handshake: a word is accepted when in_valid&in_ready on the rising edge.
- Output handshake: a word completes when out_valid&out_ready on the rising edge.
- Stage 1 registers DATA_IN masked to K bits plus the mode. Stage 2 registers the codeword and out_err.
- Latency: 2 cycles from input accept to out_valid when there is no backpressure.
- Advance rules:
  - stage2 loads when stage2 is empty or completing its output handshake this cycle.
  - stage1 loads when stage1 is empty or advancing into stage2 this cycle.
  - in_ready = !s1_valid | s1_advance (combinational from out_ready).
- Backpressure:
  - With out_ready=0, up to 2 words are held.
  - Enc_Out/out_err must stay stable while out_valid&!out_ready.
  - No word may be lost or duplicated.
- Simultaneous input accept and output complete with both stages full: everything shifts in one cycle.
- Encoding:
  - Data bit d_i (i=0..K-1, d_0 = DATA_IN[0]) maps, in ascending order, to the non-power-of-two positions 3,5,6,7,9,… .
  - p_j (j=0..P-2) = XOR of the d_i whose position has bit j set.
  - p_ov = XOR of all d_i and all p_j.
  - Codeword = {d_{K-1..0}, p_ov, p_{P-2..0}}, so the parity field occupies bits [P-1:0] with p_ov at bit P-1. Bits above K+P are 0.
- Illegal width 11: the word is still accepted; output Enc_Out=0 with out_err=1. It counts in enc_count.
- enc_count increments on each output handshake and wraps modulo 2^CNT_WIDTH.
- out_err is meaningful only while out_valid=1; it is 0 otherwise.

Decomposition:
- Package ecc_enc_pkg holds:
  - mode constants MODE_S/M/L/ILL;
  - per-mode K and P values;
  - a function mapping data index to Hamming position.
- Sub-module ecc_parity_gen: purely combinational; inputs are the 26-bit data and the mode; outputs are the 32-bit codeword and err. It is instantiated between stage1 and stage2.

Test Plan:
- After reset, width=00, DATA_IN=32'h0000000B, out_ready=1 → 2 cycles later Enc_Out=32'h000000B1, out_err=0, enc_count=1.
- Back-to-back stream of three words, out_ready=1:
  - width=00, data 4'hF → 32'h000000FF.
  - width=01, data 11'h7FF → 32'h0000FFFF.
  - width=10, data 26'h3FFFFFF → 32'hFFFFFFFF.
  - Expected: consecutive cycles, in_ready held 1.
- Upper-bit masking: width=00, DATA_IN=32'hFFFFFFF0 → 32'h00000000 (data bits above K=4 ignored).
- Backpressure:
  - out_ready=0 and push 3 words → in_ready drops after 2 accepts; Enc_Out is stable.
  - Release out_ready → words emerge in order, none lost; enc_count=3.
- Illegal mode: width=11, DATA_IN=32'h12345678 → Enc_Out=0, out_err=1, enc_count increments.
- Reset mid-stream: assert rst=0 while 2 words are held → out_valid=0 immediately; after release, a new word encodes correctly with enc_count=1.
